// File: rtl/serial_data_compare.sv
// Nibble-serial magnitude comparator: walks two wide operands MSB nibble first,
// one 4-bit compare per clock, and stops on the first differing nibble.
module serial_data_compare #(
  parameter int NIBBLES = 4
) (
  input  logic                 iClk,
  input  logic                 iReset,
  input  logic                 iStart,
  input  logic [4*NIBBLES-1:0] iData_a,
  input  logic [4*NIBBLES-1:0] iData_b,
  input  logic [2:0]           iData,
  output logic                 oBusy,
  output logic                 oDone,
  output logic [2:0]           oData
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);

  typedef enum logic {IDLE, COMPARE} state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [2:0]      r_cascade;
  logic [CW-1:0]   r_idx;

  logic [3:0]      w_a_nib;
  logic [3:0]      w_b_nib;
  logic            w_gt;
  logic            w_lt;
  logic            w_last;
  logic            w_decide;
  logic [2:0]      w_result;

  // Operands shift left once per equal nibble, so nibble k always sits at the top.
  assign w_a_nib  = r_a[W-1 -: 4];
  assign w_b_nib  = r_b[W-1 -: 4];
  assign w_gt     = (w_a_nib > w_b_nib);
  assign w_lt     = (w_a_nib < w_b_nib);
  assign w_last   = (r_idx == LAST_NIB);
  assign w_decide = w_gt || w_lt || w_last;

  always_comb begin
    w_result = r_cascade;
    if (w_gt)
      w_result = 3'b100;
    else if (w_lt)
      w_result = 3'b010;
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_cascade <= '0;
      r_idx     <= '0;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
      oData     <= 3'b000;
    end else begin
      oDone <= 1'b0;
      case (r_state)
        IDLE: begin
          if (iStart) begin
            r_a       <= iData_a;
            r_b       <= iData_b;
            r_cascade <= iData;
            r_idx     <= '0;
            oBusy     <= 1'b1;
            r_state   <= COMPARE;
          end
        end
        COMPARE: begin
          if (w_decide) begin
            oData   <= w_result;
            oDone   <= 1'b1;
            oBusy   <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_idx <= r_idx + 1'b1;
            r_a   <= r_a << 4;
            r_b   <= r_b << 4;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_data_compare.sv
// Directed bench for serial_data_compare (NIBBLES=4): latency, early stop,
// cascade pass-through, operand isolation, ignored restarts, async reset.
module tb_serial_data_compare;

  logic        iClk;
  logic        iReset;
  logic        iStart;
  logic [15:0] iData_a;
  logic [15:0] iData_b;
  logic [2:0]  iData;
  logic        oBusy;
  logic        oDone;
  logic [2:0]  oData;

  int checks   = 0;
  int failures = 0;

  serial_data_compare #(.NIBBLES(4)) dut (
    .iClk    (iClk),
    .iReset  (iReset),
    .iStart  (iStart),
    .iData_a (iData_a),
    .iData_b (iData_b),
    .iData   (iData),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oData   (oData)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Status triple checked together: {busy, done, data}.
  task automatic expect_st(input string tag, input logic b, input logic d, input logic [2:0] r);
    check(tag, {27'd0, b, d, r}, {27'd0, b, d, r} ^ {27'd0, oBusy ^ b, oDone ^ d, oData ^ r});
    $display("%s busy=%0b done=%0b data=%03b", tag, oBusy, oDone, oData);
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic [2:0] c);
    iData_a = a;
    iData_b = b;
    iData   = c;
    iStart  = 1'b1;
    tick();
    iStart  = 1'b0;
  endtask

  logic [2:0] casc_tab [4];

  initial begin
    casc_tab[0] = 3'b100;
    casc_tab[1] = 3'b010;
    casc_tab[2] = 3'b001;
    casc_tab[3] = 3'b000;

    iReset = 1'b1; iStart = 1'b0; iData_a = '0; iData_b = '0; iData = '0;
    tick(); tick();
    iReset = 1'b0;
    tick();
    check("reset_busy", {31'd0, oBusy}, 32'd0);
    check("reset_done", {31'd0, oDone}, 32'd0);
    check("reset_data", {29'd0, oData}, 32'd0);

    // 1: first nibble decides
    launch(16'h9000, 16'h1FFF, 3'b001);
    check("t1_e0_busy", {31'd0, oBusy}, 32'd1);
    check("t1_e0_done", {31'd0, oDone}, 32'd0);
    tick();
    check("t1_e1_done", {31'd0, oDone}, 32'd1);
    check("t1_e1_busy", {31'd0, oBusy}, 32'd0);
    check("t1_e1_data", {29'd0, oData}, 32'h4);
    tick();
    check("t1_e2_done", {31'd0, oDone}, 32'd0);
    check("t1_e2_data", {29'd0, oData}, 32'h4);
    $display("t1 done data=%03b", oData);

    // 2: last nibble decides, operands disturbed mid-compare
    launch(16'h1234, 16'h1235, 3'b001);
    iData_a = 16'hFFFF;
    iData_b = 16'h0000;
    iData   = 3'b100;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("t2_e%0d_busy", i), {31'd0, oBusy}, 32'd1);
      check($sformatf("t2_e%0d_done", i), {31'd0, oDone}, 32'd0);
    end
    tick();
    check("t2_e4_done", {31'd0, oDone}, 32'd1);
    check("t2_e4_busy", {31'd0, oBusy}, 32'd0);
    check("t2_e4_data", {29'd0, oData}, 32'h2);
    $display("t2 done data=%03b", oData);

    // 3: all equal, cascade passed through verbatim
    for (int r = 0; r < 4; r++) begin
      launch(16'h8888, 16'h8888, casc_tab[r]);
      tick(); tick(); tick();
      check($sformatf("t3_r%0d_e3_done", r), {31'd0, oDone}, 32'd0);
      tick();
      check($sformatf("t3_r%0d_e4_done", r), {31'd0, oDone}, 32'd1);
      check($sformatf("t3_r%0d_data", r), {29'd0, oData}, {29'd0, casc_tab[r]});
      $display("t3 run %0d data=%03b", r, oData);
      tick();
    end

    // 4: restart while busy is ignored
    launch(16'hA000, 16'hA100, 3'b001);
    iData_a = 16'hFFFF;
    iData_b = 16'h0000;
    iStart  = 1'b1;
    tick();
    iStart  = 1'b0;
    check("t4_e1_busy", {31'd0, oBusy}, 32'd1);
    check("t4_e1_done", {31'd0, oDone}, 32'd0);
    tick();
    check("t4_e2_done", {31'd0, oDone}, 32'd1);
    check("t4_e2_data", {29'd0, oData}, 32'h2);
    for (int i = 3; i <= 7; i++) begin
      tick();
      check($sformatf("t4_e%0d_done", i), {31'd0, oDone}, 32'd0);
      check($sformatf("t4_e%0d_busy", i), {31'd0, oBusy}, 32'd0);
    end
    $display("t4 done data=%03b", oData);

    // 5: asynchronous reset mid-compare
    launch(16'h0001, 16'h0000, 3'b001);
    tick();
    #2 iReset = 1'b1;
    #1;
    check("t5_rst_busy", {31'd0, oBusy}, 32'd0);
    check("t5_rst_done", {31'd0, oDone}, 32'd0);
    check("t5_rst_data", {29'd0, oData}, 32'd0);
    tick();
    #2 iReset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("t5_post%0d_done", i), {31'd0, oDone}, 32'd0);
      check($sformatf("t5_post%0d_busy", i), {31'd0, oBusy}, 32'd0);
    end
    launch(16'h0001, 16'h0000, 3'b001);
    tick(); tick(); tick();
    check("t5_again_e3_done", {31'd0, oDone}, 32'd0);
    tick();
    check("t5_again_e4_done", {31'd0, oDone}, 32'd1);
    check("t5_again_data", {29'd0, oData}, 32'h4);
    $display("t5 done data=%03b", oData);
    tick();

    // 6: start held across the done cycle -> back-to-back accept
    iData_a = 16'h9000;
    iData_b = 16'h1FFF;
    iData   = 3'b001;
    iStart  = 1'b1;
    tick();
    check("t6_e0_busy", {31'd0, oBusy}, 32'd1);
    iData_a = 16'h0000;
    iData_b = 16'h1000;
    tick();
    check("t6_e1_done", {31'd0, oDone}, 32'd1);
    check("t6_e1_data", {29'd0, oData}, 32'h4);
    tick();
    iStart = 1'b0;
    check("t6_e2_busy", {31'd0, oBusy}, 32'd1);
    check("t6_e2_done", {31'd0, oDone}, 32'd0);
    check("t6_e2_data", {29'd0, oData}, 32'h4);
    tick();
    check("t6_e3_done", {31'd0, oDone}, 32'd1);
    check("t6_e3_busy", {31'd0, oBusy}, 32'd0);
    check("t6_e3_data", {29'd0, oData}, 32'h2);
    $display("t6 done data=%03b", oData);
    tick();
    check("t6_e4_done", {31'd0, oDone}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
